// File: rtl/cadd_pipe.sv
// Two-stage complex adder/subtractor with optional round-half-up halving,
// per-component saturation and a saturating count of clamped output beats.
module cadd_pipe #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] a_r,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_r,
  input  logic signed [DW-1:0] b_i,
  input  logic                 op_sub,
  input  logic                 scale,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic                 sat_r,
  output logic                 sat_i,
  input  logic                 clr_cnt,
  output logic [CW-1:0]        sat_cnt
);

  localparam int unsigned EW = DW + 2;
  localparam logic signed [EW-1:0] SMAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {3'b111, {(DW-1){1'b0}}};

  // One component: returns {sat, result}. Two guard bits keep sum and sum+1 exact.
  function automatic logic [DW:0] comp_calc(input logic signed [DW-1:0] a,
                                            input logic signed [DW-1:0] b,
                                            input logic sub,
                                            input logic scl);
    logic signed [EW-1:0] ea;
    logic signed [EW-1:0] eb;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] val;
    logic [DW:0]          res;
    ea  = signed'({{2{a[DW-1]}}, a});
    eb  = signed'({{2{b[DW-1]}}, b});
    sum = sub ? (ea - eb) : (ea + eb);
    rnd = sum + EW'(1);
    val = scl ? (rnd >>> 1) : sum;
    if (val > SMAX) begin
      res = {1'b1, SMAX[DW-1:0]};
    end else if (val < SMIN) begin
      res = {1'b1, SMIN[DW-1:0]};
    end else begin
      res = {1'b0, val[DW-1:0]};
    end
    return res;
  endfunction

  logic                 s1_valid_q;
  logic signed [DW-1:0] s1_ar_q, s1_ai_q, s1_br_q, s1_bi_q;
  logic                 s1_sub_q, s1_scl_q;
  logic                 s2_valid_q;
  logic signed [DW-1:0] s2_r_q, s2_i_q;
  logic                 s2_satr_q, s2_sati_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW:0]          res_r, res_i;
  logic                 adv1, adv2;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  assign res_r = comp_calc(s1_ar_q, s1_br_q, s1_sub_q, s1_scl_q);
  assign res_i = comp_calc(s1_ai_q, s1_bi_q, s1_sub_q, s1_scl_q);

  // S1: operand and mode capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_ar_q    <= '0;
      s1_ai_q    <= '0;
      s1_br_q    <= '0;
      s1_bi_q    <= '0;
      s1_sub_q   <= 1'b0;
      s1_scl_q   <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      s1_ar_q    <= a_r;
      s1_ai_q    <= a_i;
      s1_br_q    <= b_r;
      s1_bi_q    <= b_i;
      s1_sub_q   <= op_sub;
      s1_scl_q   <= scale;
    end
  end

  // S2: saturated result and flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      s2_r_q     <= '0;
      s2_i_q     <= '0;
      s2_satr_q  <= 1'b0;
      s2_sati_q  <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      s2_r_q     <= res_r[DW-1:0];
      s2_i_q     <= res_i[DW-1:0];
      s2_satr_q  <= res_r[DW];
      s2_sati_q  <= res_i[DW];
    end
  end

  // Clear wins over increment; counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready && (s2_satr_q || s2_sati_q) &&
                 (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_r     = s2_r_q;
  assign out_i     = s2_i_q;
  assign sat_r     = s2_satr_q;
  assign sat_i     = s2_sati_q;
  assign sat_cnt   = cnt_q;

endmodule
